mant_norm_arbiter: RTL and testbench

MANT_NORM_ARBITER -- requirements
Module: mant_norm_arbiter

---
 rtl/mant_norm_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mant_norm_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_norm_arbiter.sv
// Two-requester round-robin arbiter feeding a multi-cycle mantissa
// normalizer: leading-one detect, left shift, exponent adjust.
//
// Ports:
//   clock, reset (async, active-low)
//   io_reqN_valid/ready/mant/exp  requester N operand handshake (N=0,1)
//   io_out_valid/ready            result handshake
//   io_out_mant/exp/id/zero       normalized result, owner, zero flag
//   io_busy                       FSM not in IDLE
module mant_norm_arbiter #(
   parameter int WIDTH = 52,
   parameter int EXPW  = 11
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_req0_valid,
   output logic             io_req0_ready,
   input  logic [WIDTH-1:0] io_req0_mant,
   input  logic [EXPW-1:0]  io_req0_exp,
   input  logic             io_req1_valid,
   output logic             io_req1_ready,
   input  logic [WIDTH-1:0] io_req1_mant,
   input  logic [EXPW-1:0]  io_req1_exp,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_mant,
   output logic [EXPW-1:0]  io_out_exp,
   output logic             io_out_id,
   output logic             io_out_zero,
   output logic             io_busy
);

   localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // Compare width wide enough for either operand plus headroom.
   localparam int CW = ((EXPW > LW) ? EXPW : LW) + 1;

   typedef enum logic [1:0] {
      IDLE,
      DETECT,
      SHIFT,
      OUT
   } stateT;

   stateT            state;
   logic             rr;
   logic [WIDTH-1:0] mantReg;
   logic [EXPW-1:0]  expReg;
   logic             idReg;
   logic [LW-1:0]    leadReg;
   logic             zeroReg;

   logic [WIDTH-1:0] outMant;
   logic [EXPW-1:0]  outExp;
   logic             outId;
   logic             outZero;

   logic             isIdle;
   logic             grant1;
   logic             take0;
   logic             take1;
   logic             xfer;
   logic [WIDTH-1:0] selMant;
   logic [EXPW-1:0]  selExp;
   logic [LW-1:0]    leadIdx;
   logic [LW-1:0]    shiftAmt;
   logic             underflow;

   assign isIdle = (state == IDLE);

   // Requester 1 wins when alone, or when both ask and rr points at it.
   assign grant1 = io_req1_valid & (~io_req0_valid | rr);
   assign take0  = isIdle & io_req0_valid & ~grant1;
   assign take1  = isIdle & grant1;
   assign xfer   = take0 | take1;

   assign io_req0_ready = take0;
   assign io_req1_ready = take1;

   always_comb begin
      selMant = io_req0_mant;
      selExp  = io_req0_exp;
      unique case (1'b1)
         take1: begin
            selMant = io_req1_mant;
            selExp  = io_req1_exp;
         end
         default: ;
      endcase
   end

   // Highest set bit wins: later iterations overwrite lower hits.
   always_comb begin
      leadIdx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mantReg[i]) begin
            leadIdx = LW'(i);
         end
      end
   end

   assign shiftAmt  = LW'(WIDTH - 1) - leadReg;
   assign underflow = CW'(expReg) < CW'(shiftAmt);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rr      <= 1'b0;
         mantReg <= '0;
         expReg  <= '0;
         idReg   <= 1'b0;
         leadReg <= '0;
         zeroReg <= 1'b0;
         outMant <= '0;
         outExp  <= '0;
         outId   <= 1'b0;
         outZero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer) begin
                  mantReg <= selMant;
                  expReg  <= selExp;
                  idReg   <= take1;
                  // Point at the loser so it wins the next tie.
                  rr      <= take0;
                  state   <= DETECT;
               end
            end
            DETECT: begin
               leadReg <= leadIdx;
               zeroReg <= ~|mantReg;
               state   <= SHIFT;
            end
            SHIFT: begin
               outId <= idReg;
               if (zeroReg || underflow) begin
                  outMant <= '0;
                  outExp  <= '0;
                  outZero <= 1'b1;
               end else begin
                  outMant <= mantReg << shiftAmt;
                  // Safe narrowing: here expReg >= shiftAmt.
                  outExp  <= expReg - EXPW'(shiftAmt);
                  outZero <= 1'b0;
               end
               state <= OUT;
            end
            OUT: begin
               if (io_out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io_out_valid = (state == OUT);
   assign io_out_mant  = outMant;
   assign io_out_exp   = outExp;
   assign io_out_id    = outId;
   assign io_out_zero  = outZero;
   assign io_busy      = ~isIdle;

endmodule

// File: tb/tb_mant_norm_arbiter.sv
// Randomized scoreboard bench for mant_norm_arbiter.
// Reference normalizes by repeated doubling with a signed exponent.
module tb_mant_norm_arbiter;

   localparam int W = 52;
   localparam int E = 11;

   typedef struct {
      logic [W-1:0] mant;
      logic [E-1:0] exp;
      bit           id;
      bit           zero;
   } resT;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         v0 = 1'b0;
   logic         v1 = 1'b0;
   logic         r0;
   logic         r1;
   logic [W-1:0] m0 = '0;
   logic [W-1:0] m1 = '0;
   logic [E-1:0] e0 = '0;
   logic [E-1:0] e1 = '0;
   logic         oValid;
   logic         oReady = 1'b1;
   logic [W-1:0] oMant;
   logic [E-1:0] oExp;
   logic         oId;
   logic         oZero;
   logic         busy;

   int  nChecks = 0;
   int  nFails  = 0;

   resT sb[$];
   bit  seen[$];

   bit  mIdle  = 1'b1;
   int  mStage = 0;
   bit  mRr    = 1'b0;

   mant_norm_arbiter #(.WIDTH(W), .EXPW(E)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_req0_valid(v0),
      .io_req0_ready(r0),
      .io_req0_mant (m0),
      .io_req0_exp  (e0),
      .io_req1_valid(v1),
      .io_req1_ready(r1),
      .io_req1_mant (m1),
      .io_req1_exp  (e1),
      .io_out_valid (oValid),
      .io_out_ready (oReady),
      .io_out_mant  (oMant),
      .io_out_exp   (oExp),
      .io_out_id    (oId),
      .io_out_zero  (oZero),
      .io_busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, act, req, $time);
      end
   endtask

   function automatic resT refNorm(logic [W-1:0] m, logic [E-1:0] e,
                                   bit id);
      resT r;
      int  ex;
      ex   = int'(e);
      r.id = id;
      if (m == '0) begin
         r.mant = '0;
         r.exp  = '0;
         r.zero = 1'b1;
         return r;
      end
      while (!m[W-1]) begin
         m  = m << 1;
         ex = ex - 1;
      end
      if (ex < 0) begin
         r.mant = '0;
         r.exp  = '0;
         r.zero = 1'b1;
      end else begin
         r.mant = m;
         r.exp  = E'(ex);
         r.zero = 1'b0;
      end
      return r;
   endfunction

   // Cycle-level reference: arbitration and handshake expectations.
   always @(negedge clock) begin
      bit x0;
      bit x1;
      if (!reset) begin
         mIdle  = 1'b1;
         mStage = 0;
         mRr    = 1'b0;
         sb.delete();
      end else if (mIdle) begin
         x0 = v0 && (!v1 || !mRr);
         x1 = v1 && (!v0 || mRr);
         chk("ready0", r0, x0);
         chk("ready1", r1, x1);
         chk("busyIdle", busy, 0);
         chk("validIdle", oValid, 0);
         if (x0 || x1) begin
            if (x1) sb.push_back(refNorm(m1, e1, 1'b1));
            else    sb.push_back(refNorm(m0, e0, 1'b0));
            mRr    = x0;
            mIdle  = 1'b0;
            mStage = 0;
         end
      end else begin
         mStage++;
         chk("ready0Busy", r0, 0);
         chk("ready1Busy", r1, 0);
         chk("busy", busy, 1);
         chk("outValid", oValid, mStage >= 3);
         if (mStage >= 3 && oReady) mIdle = 1'b1;
      end
   end

   // Monitor: compare presented results against the scoreboard head.
   always @(negedge clock) begin
      if (reset && oValid) begin
         if (sb.size() == 0) begin
            chk("unexpectedOut", 1, 0);
         end else begin
            chk("outMant", oMant, sb[0].mant);
            chk("outExp", oExp, sb[0].exp);
            chk("outId", oId, sb[0].id);
            chk("outZero", oZero, sb[0].zero);
            if (oReady) void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
   endtask

   task automatic issue(bit id, logic [W-1:0] m, logic [E-1:0] e);
      bit got;
      got = 1'b0;
      if (id) begin
         m1 = m;
         e1 = e;
         v1 = 1'b1;
      end else begin
         m0 = m;
         e0 = e;
         v0 = 1'b1;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if ((id && r1) || (!id && r0)) got = 1'b1;
         @(posedge clock);
         #1;
      end
      if (!got) chk("issueTimeout", 0, 1);
      v0 = 1'b0;
      v1 = 1'b0;
   endtask

   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clock);
         if (mIdle && sb.size() == 0) done = 1'b1;
      end
      if (!done) chk("idleTimeout", 0, 1);
      step();
   endtask

   function automatic logic [W-1:0] randMant();
      logic [63:0] t;
      case ($urandom_range(0, 3))
         0: return '0;
         1: begin
            t = 64'd1 << $urandom_range(0, W - 1);
            return t[W-1:0];
         end
         default: begin
            t = {$urandom(), $urandom()};
            t = t >> $urandom_range(12, 64);
            return t[W-1:0];
         end
      endcase
   endfunction

   function automatic logic [E-1:0] randExp();
      if ($urandom_range(0, 1) == 1) return E'($urandom_range(0, 60));
      return E'($urandom_range(0, (1 << E) - 1));
   endfunction

   initial begin
      int pos;
      logic [63:0] one;

      // Reset state.
      #2;
      chk("rstValid", oValid, 0);
      chk("rstBusy", busy, 0);
      chk("rstMant", oMant, 0);
      chk("rstExp", oExp, 0);
      chk("rstId", oId, 0);
      chk("rstZero", oZero, 0);
      repeat (2) step();
      reset = 1'b1;

      // Single op.
      issue(0, W'(1), E'(100));
      waitIdle();

      // Contention from reset; log grants seen on the DUT readies.
      v0 = 1'b0;
      v1 = 1'b0;
      reset = 1'b0;
      step();
      m0 = W'(1) << (W - 1);
      m1 = W'(1) << (W - 1);
      e0 = E'(60);
      e1 = E'(70);
      v0 = 1'b1;
      v1 = 1'b1;
      oReady = 1'b1;
      step();
      reset = 1'b1;
      seen.delete();
      for (int i = 0; i < 40 && seen.size() < 3; i++) begin
         @(negedge clock);
         if (r0) seen.push_back(1'b0);
         if (r1) seen.push_back(1'b1);
         @(posedge clock);
         #1;
      end
      v0 = 1'b0;
      v1 = 1'b0;
      chk("grantCount", seen.size(), 3);
      if (seen.size() >= 3) begin
         chk("grant0", seen[0], 0);
         chk("grant1", seen[1], 1);
         chk("grant2", seen[2], 0);
      end
      waitIdle();

      // Zero and underflow.
      issue(1, '0, E'(77));
      waitIdle();
      issue(0, W'(1), E'(10));
      waitIdle();
      issue(1, W'(1) << 9, E'(42));
      waitIdle();

      // Backpressure held for several OUT cycles.
      oReady = 1'b0;
      issue(1, W'(64'h123456789), E'(900));
      repeat (8) step();
      oReady = 1'b1;
      waitIdle();

      // Reset while in SHIFT: asynchronous clear, op discarded.
      issue(1, W'(5), E'(300));
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("midRstValid", oValid, 0);
      chk("midRstBusy", busy, 0);
      chk("midRstMant", oMant, 0);
      chk("midRstExp", oExp, 0);
      chk("midRstId", oId, 0);
      chk("midRstZero", oZero, 0);
      step();
      reset = 1'b1;
      repeat (6) step();

      // Single-bit sweep.
      for (int p = 0; p < W; p++) begin
         pos = p;
         one = 64'd1 << pos;
         issue(bit'(p & 1), one[W-1:0], E'(60));
         waitIdle();
      end

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         v0 = ($urandom_range(0, 99) < 55);
         v1 = ($urandom_range(0, 99) < 55);
         m0 = randMant();
         m1 = randMant();
         e0 = randExp();
         e1 = randExp();
         oReady = ($urandom_range(0, 99) < 70);
         step();
      end
      v0 = 1'b0;
      v1 = 1'b0;
      oReady = 1'b1;
      waitIdle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
